// File: rtl/pim_pkg.sv
// pim_pkg: opcodes, sequencer state encoding and response error codes shared by the PIM op sequencer.
package pim_pkg;
  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic ERR_NONE = 1'b0;
  localparam logic ERR_FAIL = 1'b1;
  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_RD_B, S_CAP_B, S_EXEC, S_WB, S_RSP
  } seq_state_t;
  function automatic logic op_legal(input logic [1:0] op);
    return op == OP_ADD || op == OP_MUL;
  endfunction
endpackage

// File: rtl/pim_op_sequencer_if.sv
// pim_op_sequencer_if: command, bank, ALU and response signals of the PIM op sequencer.
interface pim_op_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int ID_W   = 5
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr_a;
  logic [ADDR_W-1:0] cmd_addr_b;
  logic [ADDR_W-1:0] cmd_addr_d;
  logic [ID_W-1:0]   cmd_id;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [1:0]        alu_operation;
  logic [ID_W-1:0]   alu_id;
  logic [DATA_W-1:0] alu_result;
  logic              alu_op_done;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  modport master (
    input  cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_addr_d, cmd_id,
    input  mem_rd_data, alu_result, alu_op_done, rsp_ready,
    output cmd_ready, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    output alu_a, alu_b, alu_operation, alu_id, rsp_valid, rsp_id, rsp_data, rsp_err
  );
  modport slave (
    output cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_addr_d, cmd_id,
    output mem_rd_data, alu_result, alu_op_done, rsp_ready,
    input  cmd_ready, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    input  alu_a, alu_b, alu_operation, alu_id, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/pim_op_sequencer.sv
// pim_op_sequencer: fetches two operands, runs the PIM ALU, writes back and responds; one command in flight.
// Define PIM_SEQ_TIMEOUT_EN to add the EXEC watchdog (TIMEOUT_CYC cycles, reported as rsp_err).
module pim_op_sequencer
  import pim_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int ID_W        = 5,
  parameter int TIMEOUT_CYC = 64
) (
  input logic clk,
  input logic rst,
  pim_op_sequencer_if.master bus
);
  seq_state_t        state;
  logic [1:0]        op;
  logic [ADDR_W-1:0] addr_b;
  logic [ADDR_W-1:0] addr_d;
  logic              expired;
`ifdef PIM_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] cnt;
  always_ff @(posedge clk) cnt <= (rst || state != S_EXEC) ? '0 : cnt + 1'b1;
  assign expired = state == S_EXEC && cnt == TO_W'(TIMEOUT_CYC - 1);
`else
  assign expired = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      op                <= OP_NOP;
      addr_b            <= '0;
      addr_d            <= '0;
      bus.cmd_ready     <= 1'b1;
      bus.mem_rd_en     <= 1'b0;
      bus.mem_rd_addr   <= '0;
      bus.mem_wr_en     <= 1'b0;
      bus.mem_wr_addr   <= '0;
      bus.mem_wr_data   <= '0;
      bus.alu_a         <= '0;
      bus.alu_b         <= '0;
      bus.alu_operation <= OP_NOP;
      bus.alu_id        <= '0;
      bus.rsp_valid     <= 1'b0;
      bus.rsp_id        <= '0;
      bus.rsp_data      <= '0;
      bus.rsp_err       <= ERR_NONE;
    end else begin
      bus.mem_rd_en <= 1'b0;
      bus.mem_wr_en <= 1'b0;
      case (state)
        S_IDLE: if (bus.cmd_valid) begin
          op            <= bus.cmd_op;
          addr_b        <= bus.cmd_addr_b;
          addr_d        <= bus.cmd_addr_d;
          bus.alu_id    <= bus.cmd_id;
          bus.rsp_id    <= bus.cmd_id;
          bus.cmd_ready <= 1'b0;
          if (op_legal(bus.cmd_op)) begin
            state           <= S_RD_A;
            bus.mem_rd_en   <= 1'b1;
            bus.mem_rd_addr <= bus.cmd_addr_a;
          end else begin
            state         <= S_RSP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= ERR_FAIL;
            bus.rsp_data  <= '0;
          end
        end
        S_RD_A: begin
          state           <= S_RD_B;
          bus.mem_rd_en   <= 1'b1;
          bus.mem_rd_addr <= addr_b;
        end
        S_RD_B: begin
          state     <= S_CAP_B;
          bus.alu_a <= bus.mem_rd_data;
        end
        S_CAP_B: begin
          state             <= S_EXEC;
          bus.alu_b         <= bus.mem_rd_data;
          bus.alu_operation <= op;
        end
        // A completion on the expiry cycle takes priority over the watchdog.
        S_EXEC: if (bus.alu_op_done) begin
          state             <= S_WB;
          bus.alu_operation <= OP_NOP;
          bus.mem_wr_en     <= 1'b1;
          bus.mem_wr_addr   <= addr_d;
          bus.mem_wr_data   <= bus.alu_result;
          bus.rsp_data      <= bus.alu_result;
          bus.rsp_err       <= ERR_NONE;
        end else if (expired) begin
          state             <= S_RSP;
          bus.alu_operation <= OP_NOP;
          bus.rsp_valid     <= 1'b1;
          bus.rsp_err       <= ERR_FAIL;
          bus.rsp_data      <= '0;
        end
        S_WB: begin
          state         <= S_RSP;
          bus.rsp_valid <= 1'b1;
        end
        S_RSP: if (bus.rsp_ready) begin
          state         <= S_IDLE;
          bus.rsp_valid <= 1'b0;
          bus.cmd_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pim_op_sequencer.sv
// tb_pim_op_sequencer: table-driven and randomized checks of pim_op_sequencer against a bank/ALU model.
module tb_pim_op_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pim_op_sequencer_if bus ();
  pim_op_sequencer #(.TIMEOUT_CYC(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  a, b, d;
    logic [4:0]  id;
    logic [15:0] av, bv;
    int          lat, hold;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_t;

  logic [15:0] bank [256];
  logic [15:0] shadow [256];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;
  int          wr_total = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          lat = 0;
  logic        hang = 1'b0;
  logic        stray = 1'b0;
  logic        stub_done = 1'b0;
  int          alu_cnt = 0;

  function automatic logic [15:0] ref_alu(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    return op == 2'b01 ? a + b : {8'h00, a[7:0]} * {8'h00, b[7:0]};
  endfunction

  always @(posedge clk) begin
    if (pl_en) bank[pl_addr] <= pl_data;
    if (bus.mem_rd_en) bus.mem_rd_data <= bank[bus.mem_rd_addr];
    if (bus.mem_wr_en) begin
      bank[bus.mem_wr_addr] <= bus.mem_wr_data;
      wr_total <= wr_total + 1;
    end
  end

  // ALU stub: pulses op_done lat cycles after the opcode appears, then waits for a NOP to re-arm.
  always @(posedge clk) begin
    bus.alu_result <= ref_alu(bus.alu_operation, bus.alu_a, bus.alu_b);
    if (bus.alu_operation == 2'b00) begin
      alu_cnt   <= 0;
      stub_done <= 1'b0;
    end else begin
      alu_cnt   <= alu_cnt + 1;
      stub_done <= !hang && alu_cnt == lat;
    end
  end
  assign bus.alu_op_done = stub_done | stray;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] v);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = v; shadow[a] = v;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] d, input logic [4:0] id, input int l, input int h);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.d = d; v.id = id; v.lat = l; v.hold = h;
    v.av = shadow[a]; v.bv = shadow[b];
    v.exp_err  = !(op == 2'b01 || op == 2'b10);
    v.exp_data = v.exp_err ? 16'h0000 : ref_alu(op, v.av, v.bv);
    return v;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] d, input logic [4:0] id);
    int n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr_a = a; bus.cmd_addr_b = b;
    bus.cmd_addr_d = d; bus.cmd_id = id;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_before_issue", 32'(bus.cmd_ready), 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run(input vec_t v);
    int rd_cnt = 0, wr_cnt = 0, op_c = 0, done_c = 0, wr_c = 0, rsp_c = 0;
    logic [7:0]  rd_a = '0, rd_b = '0, wr_addr = '0;
    logic [15:0] wr_data = '0, data_s;
    logic [4:0]  id_s;
    logic        err_s, opnd_ok = 1'b1, nop_ok = 1'b1, stable = 1'b1;
    lat = v.lat;
    issue(v.op, v.a, v.b, v.d, v.id);
    for (int c = 1; c <= 200; c++) begin
      if (bus.mem_rd_en) begin
        rd_cnt++;
        if (rd_cnt == 1) rd_a = bus.mem_rd_addr; else rd_b = bus.mem_rd_addr;
      end
      if (bus.mem_wr_en) begin
        wr_cnt++; wr_c = c; wr_addr = bus.mem_wr_addr; wr_data = bus.mem_wr_data;
      end
      if (bus.alu_operation != 2'b00) begin
        if (op_c == 0) op_c = c;
        if (done_c != 0) nop_ok = 1'b0;
        if (bus.alu_operation != v.op || bus.alu_a != v.av || bus.alu_b != v.bv || bus.alu_id != v.id)
          opnd_ok = 1'b0;
        if (bus.alu_op_done) done_c = c;
      end
      if (bus.rsp_valid) begin
        rsp_c = c;
        break;
      end
      @(negedge clk);
    end
    check("rsp_seen", 32'(rsp_c != 0), 1);
    check("rsp_id", 32'(bus.rsp_id), 32'(v.id));
    check("rsp_data", 32'(bus.rsp_data), 32'(v.exp_data));
    check("rsp_err", 32'(bus.rsp_err), 32'(v.exp_err));
    if (v.exp_err) begin
      check("illegal_rsp_cycle", rsp_c, 1);
      check("illegal_mem_reads", rd_cnt, 0);
      check("illegal_mem_writes", wr_cnt, 0);
    end else begin
      check("opcode_cycle", op_c, 4);
      check("mem_reads", rd_cnt, 2);
      check("rd_addr_a", 32'(rd_a), 32'(v.a));
      check("rd_addr_b", 32'(rd_b), 32'(v.b));
      check("mem_writes", wr_cnt, 1);
      check("wr_addr", 32'(wr_addr), 32'(v.d));
      check("wr_data", 32'(wr_data), 32'(v.exp_data));
      check("wb_after_done", wr_c, done_c + 1);
      check("rsp_after_done", rsp_c, done_c + 2);
      check("alu_operands_stable", 32'(opnd_ok), 1);
      check("nop_after_done", 32'(nop_ok), 1);
    end
    id_s = bus.rsp_id; data_s = bus.rsp_data; err_s = bus.rsp_err;
    for (int h = 0; h < v.hold; h++) begin
      bus.cmd_valid = 1'b1; bus.cmd_op = 2'b01;
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_id !== id_s || bus.rsp_data !== data_s || bus.rsp_err !== err_s ||
          bus.cmd_ready || bus.mem_rd_en) stable = 1'b0;
    end
    if (v.hold > 0) check("rsp_hold_stable", 32'(stable), 1);
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("rsp_released", 32'(bus.rsp_valid), 0);
    check("cmd_ready_after_rsp", 32'(bus.cmd_ready), 1);
    if (!v.exp_err) shadow[v.d] = v.exp_data;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [8];
    int   n, w0, cnt_op, rsp_c;
    logic seen;
    logic [1:0] rop;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_addr_a = '0; bus.cmd_addr_b = '0;
    bus.cmd_addr_d = '0; bus.cmd_id = '0; bus.rsp_ready = 1'b0;
    tbl[0] = '{2'b01, 8'd3,  8'd4,  8'd9,  5'd2,  16'h0005, 16'h0007, 1, 0, 16'h000C, 1'b0};
    tbl[1] = '{2'b10, 8'd1,  8'd2,  8'd10, 5'd3,  16'h1234, 16'h0012, 2, 0, 16'h03A8, 1'b0};
    tbl[2] = '{2'b11, 8'd0,  8'd0,  8'd12, 5'd7,  16'h0000, 16'h0000, 0, 0, 16'h0000, 1'b1};
    tbl[3] = '{2'b00, 8'd0,  8'd0,  8'd12, 5'd8,  16'h0000, 16'h0000, 0, 1, 16'h0000, 1'b1};
    tbl[4] = '{2'b01, 8'd5,  8'd6,  8'd5,  5'd11, 16'hFFFF, 16'h0002, 0, 0, 16'h0001, 1'b0};
    tbl[5] = '{2'b10, 8'd7,  8'd7,  8'd8,  5'd31, 16'h00FF, 16'h00FF, 4, 0, 16'hFE01, 1'b0};
    tbl[6] = '{2'b01, 8'd11, 8'd12, 8'd13, 5'd16, 16'h1000, 16'h2345, 1, 5, 16'h3345, 1'b0};
    tbl[7] = '{2'b10, 8'd14, 8'd15, 8'd14, 5'd20, 16'hAB10, 16'hCD03, 3, 2, 16'h0030, 1'b0};
    repeat (3) @(negedge clk);
    check("reset_cmd_ready", 32'(bus.cmd_ready), 1);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 0);
    check("reset_mem_strobes", {30'd0, bus.mem_rd_en, bus.mem_wr_en}, 0);
    check("reset_alu_operation", 32'(bus.alu_operation), 0);
    check("reset_rsp_fields", {bus.rsp_data, 10'd0, bus.rsp_id, bus.rsp_err}, 0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) preload(8'(i), 16'($urandom));
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    check("stray_done_idle", {30'd0, bus.cmd_ready, bus.rsp_valid}, 32'h2);
    for (int i = 0; i < 8; i++) begin
      preload(tbl[i].a, tbl[i].av);
      preload(tbl[i].b, tbl[i].bv);
      run(tbl[i]);
    end
    for (int i = 0; i < 40; i++) begin
      rop = ($urandom % 8 == 0) ? (($urandom % 2 == 0) ? 2'b00 : 2'b11) : (($urandom % 2 == 0) ? 2'b01 : 2'b10);
      run(mk(rop, 8'($urandom % 16), 8'($urandom % 16), 8'($urandom % 16), 5'($urandom),
             int'($urandom % 6), int'($urandom % 4)));
    end
    // Reset while EXEC is waiting on the ALU aborts the command.
    hang = 1'b1;
    issue(2'b01, 8'd3, 8'd4, 8'd9, 5'd9);
    n = 0;
    while (bus.alu_operation == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("exec_reached", 32'(bus.alu_operation), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_cmd_ready", 32'(bus.cmd_ready), 1);
    check("abort_alu_operation", 32'(bus.alu_operation), 0);
    check("abort_outputs_zero", {bus.alu_a, 13'd0, bus.rsp_valid, bus.mem_rd_en, bus.mem_wr_en}, 0);
    rst = 1'b0;
    hang = 1'b0;
    w0 = wr_total;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.mem_wr_en) seen = 1'b1;
    end
    check("abort_no_rsp_or_write", 32'(seen), 0);
    check("abort_no_bank_write", wr_total - w0, 0);
    run(mk(2'b01, 8'd3, 8'd4, 8'd9, 5'd10, 2, 0));
`ifdef PIM_SEQ_TIMEOUT_EN
    hang = 1'b1;
    issue(2'b01, 8'd1, 8'd2, 8'd20, 5'd4);
    w0 = wr_total;
    cnt_op = 0;
    rsp_c = 0;
    for (int c = 1; c <= 60; c++) begin
      if (bus.alu_operation != 2'b00) cnt_op++;
      if (bus.rsp_valid) begin
        rsp_c = c;
        break;
      end
      @(negedge clk);
    end
    check("timeout_exec_cycles", cnt_op, 8);
    check("timeout_rsp_cycle", rsp_c, 12);
    check("timeout_rsp_err", 32'(bus.rsp_err), 1);
    check("timeout_rsp_data", 32'(bus.rsp_data), 0);
    check("timeout_rsp_id", 32'(bus.rsp_id), 4);
    check("timeout_no_write", wr_total - w0, 0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    hang = 1'b0;
    check("timeout_cmd_ready", 32'(bus.cmd_ready), 1);
    run(mk(2'b01, 8'd1, 8'd2, 8'd21, 5'd5, 6, 0));
`else
    hang = 1'b1;
    issue(2'b10, 8'd1, 8'd2, 8'd20, 5'd4);
    repeat (100) @(negedge clk);
    check("no_timeout_still_exec", 32'(bus.alu_operation), 2);
    check("no_timeout_no_rsp", 32'(bus.rsp_valid), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hang = 1'b0;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
